// File: rtl/clint_pkg.sv
// Shared register offsets, register-state type and reset image for the core-local interruptor.
package clint_pkg;

    localparam logic [31:0] clint_msip      = 32'h0000_0000;
    localparam logic [31:0] clint_mtimecmp  = 32'h0000_4000;
    localparam logic [31:0] clint_mtimecmph = 32'h0000_4004;
    localparam logic [31:0] clint_mtime     = 32'h0000_BFF8;
    localparam logic [31:0] clint_mtimeh    = 32'h0000_BFFC;

    typedef struct packed {
        logic        msip;
        logic [63:0] mtimecmp;
        logic [63:0] mtime;
        logic [15:0] prescaler;
    } clint_reg_type;

    localparam clint_reg_type init_clint_reg = '{
        msip:      1'b0,
        mtimecmp:  {64{1'b1}},
        mtime:     64'd0,
        prescaler: 16'd0
    };

    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk down to the mtime tick rate: one tick every RTC_DIV cycles.
module clint_prescaler #(
    parameter int RTC_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] last_count = 16'(RTC_DIV - 1);

    logic [15:0] count;

    assign tick = (count == last_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 16'd0;
        end else if (tick) begin
            count <= 16'd0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-cycle bus slave.
// Build option CLINT_MTIME_LATCH_EN: reading mtime low snapshots the high half for an atomic pair read.
module clint #(
    parameter int          RTC_DIV   = 1,
    parameter logic [31:0] ADDR_MASK = 32'h0000FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mtip,
    output logic        msip,
    output logic [63:0] mtime
);
    import clint_pkg::*;

    logic          tick;
    clint_reg_type r, r_next;
    logic [31:0]   off;
    logic          wr, rd;
    logic [63:0]   mtime_inc;
    logic [31:0]   rdata_next;

    clint_prescaler #(.RTC_DIV(RTC_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // The tick count itself lives in clint_prescaler; r.prescaler holds its reset image only.
    always_comb begin
        r_next    = r;
        off       = mem_addr & ADDR_MASK;
        wr        = mem_valid && !mem_instr && (mem_wstrb != 4'b0000);
        rd        = mem_valid && !wr;
        mtime_inc = tick ? r.mtime + 64'd1 : r.mtime;
        r_next.mtime = mtime_inc;
        if (wr) begin
            case (off)
                clint_msip:      if (mem_wstrb[0]) r_next.msip = mem_wdata[0];
                clint_mtimecmp:  r_next.mtimecmp[31:0]  = byte_merge(r.mtimecmp[31:0], mem_wdata, mem_wstrb);
                clint_mtimecmph: r_next.mtimecmp[63:32] = byte_merge(r.mtimecmp[63:32], mem_wdata, mem_wstrb);
                // A half-write suppresses the carry into/out of the other half.
                clint_mtime:     r_next.mtime = {r.mtime[63:32], byte_merge(mtime_inc[31:0], mem_wdata, mem_wstrb)};
                clint_mtimeh:    r_next.mtime = {byte_merge(mtime_inc[63:32], mem_wdata, mem_wstrb), r.mtime[31:0]};
                default: ;
            endcase
        end
    end

`ifdef CLINT_MTIME_LATCH_EN
    logic [31:0] mtime_shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_shadow <= 32'd0;
        end else if (rd && off == clint_mtime) begin
            mtime_shadow <= r.mtime[63:32];
        end else if (wr && off == clint_mtimeh) begin
            mtime_shadow <= r_next.mtime[63:32];
        end
    end
`endif

    always_comb begin
        rdata_next = 32'd0;
        if (rd) begin
            case (off)
                clint_msip:      rdata_next = {31'd0, r.msip};
                clint_mtimecmp:  rdata_next = r.mtimecmp[31:0];
                clint_mtimecmph: rdata_next = r.mtimecmp[63:32];
                clint_mtime:     rdata_next = r.mtime[31:0];
`ifdef CLINT_MTIME_LATCH_EN
                clint_mtimeh:    rdata_next = mtime_shadow;
`else
                clint_mtimeh:    rdata_next = r.mtime[63:32];
`endif
                default:         rdata_next = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r         <= init_clint_reg;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            mtip      <= 1'b0;
        end else begin
            r         <= r_next;
            mem_ready <= mem_valid;
            mem_rdata <= rdata_next;
            mtip      <= (r_next.mtime >= r_next.mtimecmp);
        end
    end

    assign msip  = r.msip;
    assign mtime = r.mtime;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: two instances (RTC_DIV=4 and 1) on a shared bus against a behavioural model.
module tb_clint;

`ifdef CLINT_MTIME_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        instr = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;

    logic        ready_o [2];
    logic [31:0] rdata_o [2];
    logic        mtip_o  [2];
    logic        msip_o  [2];
    logic [63:0] mtime_o [2];

    int checks = 0;
    int errors = 0;

    // behavioural model state, one entry per instance
    logic [63:0] m_mtime  [2];
    logic [63:0] m_cmp    [2];
    logic        m_msip   [2];
    logic [31:0] m_shadow [2];
    int          m_cyc    [2];
    logic        m_ready  [2];
    logic [31:0] m_rdata  [2];
    logic        m_mtip   [2];

    always #5 clk = ~clk;

    clint #(.RTC_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .mem_valid(valid), .mem_instr(instr), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata_o[0]), .mem_ready(ready_o[0]),
        .mtip(mtip_o[0]), .msip(msip_o[0]), .mtime(mtime_o[0])
    );

    clint #(.RTC_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .mem_valid(valid), .mem_instr(instr), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata_o[1]), .mem_ready(ready_o[1]),
        .mtip(mtip_o[1]), .msip(msip_o[1]), .mtime(mtime_o[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] m;
        m = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
        return (wd & m) | (old & ~m);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mtime[i] = 64'd0;  m_cmp[i] = {64{1'b1}}; m_msip[i] = 1'b0;
            m_shadow[i] = 32'd0; m_cyc[i] = 0;          m_ready[i] = 1'b0;
            m_rdata[i] = 32'd0;  m_mtip[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] off, rv;
        logic [63:0] nt, nc;
        bit is_wr, is_rd, tick;
        off   = addr & 32'h0000FFFF;
        is_wr = valid && !instr && (wstrb != 4'd0);
        is_rd = valid && !is_wr;
        for (int i = 0; i < 2; i++) begin
            rv = 32'd0;
            if (is_rd) begin
                case (off)
                    32'h0000: rv = {31'd0, m_msip[i]};
                    32'h4000: rv = m_cmp[i][31:0];
                    32'h4004: rv = m_cmp[i][63:32];
                    32'hBFF8: rv = m_mtime[i][31:0];
                    32'hBFFC: rv = LATCH ? m_shadow[i] : m_mtime[i][63:32];
                    default:  rv = 32'd0;
                endcase
            end
            m_ready[i] = valid;
            m_rdata[i] = rv;
            tick = (m_cyc[i] % div_of(i)) == div_of(i) - 1;
            m_cyc[i]++;
            nt = m_mtime[i] + (tick ? 64'd1 : 64'd0);
            nc = m_cmp[i];
            if (is_rd && off == 32'hBFF8) m_shadow[i] = m_mtime[i][63:32];
            if (is_wr) begin
                case (off)
                    32'h0000: if (wstrb[0]) m_msip[i] = wdata[0];
                    32'h4000: nc[31:0]  = merge(nc[31:0], wdata, wstrb);
                    32'h4004: nc[63:32] = merge(nc[63:32], wdata, wstrb);
                    32'hBFF8: nt = {m_mtime[i][63:32], merge(nt[31:0], wdata, wstrb)};
                    32'hBFFC: begin
                        nt = {merge(nt[63:32], wdata, wstrb), m_mtime[i][31:0]};
                        m_shadow[i] = nt[63:32];
                    end
                    default: ;
                endcase
            end
            m_mtime[i] = nt;
            m_cmp[i]   = nc;
            m_mtip[i]  = (nt >= nc);
        end
    endtask

    task automatic cyc(input logic v, input logic ins, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
        valid = v; instr = ins; addr = a; wdata = wd; wstrb = ws;
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready%0d", i), ready_o[i], m_ready[i]);
            chk($sformatf("rdata%0d", i), rdata_o[i], m_rdata[i]);
            chk($sformatf("mtip%0d", i),  mtip_o[i],  m_mtip[i]);
            chk($sformatf("msip%0d", i),  msip_o[i],  m_msip[i]);
            chk($sformatf("mtime%0d", i), mtime_o[i], m_mtime[i]);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        cyc(1'b1, 1'b0, a, wd, ws);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b1, 1'b0, a, 32'd0, 4'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        bit found;
        logic [31:0] a;
        logic [31:0] addrs [7];
        addrs = '{32'h0000, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC, 32'h1234, 32'h8000};

        // reset state and RTC_DIV=4 tick rate
        do_reset();
        chk("rst_mtime", mtime_o[0], 64'd0);
        chk("rst_ready", ready_o[0], 64'd0);
        repeat (40) idle();
        chk("t1_mtime", mtime_o[0], 64'd10);
        chk("t1_mtip",  mtip_o[0],  64'd0);
        rd(32'hBFF8);
        chk("t1_ready_lo", ready_o[0], 64'd1);
        chk("t1_rdata_lo", rdata_o[0], 64'd10);
        rd(32'h4004);
        chk("t1_ready_cmph", ready_o[0], 64'd1);
        chk("t1_rdata_cmph", rdata_o[0], 64'hFFFF_FFFF);

        // mtip rises with mtime reaching mtimecmp, clears when compare moves up
        do_reset();
        wr(32'h4000, 32'h20, 4'hF);
        wr(32'h4004, 32'h0, 4'hF);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            idle();
            if (mtime_o[1] == 64'h1F) chk("t2_mtip_below", mtip_o[1], 64'd0);
            if (mtime_o[1] == 64'h20) begin
                chk("t2_mtip_rise", mtip_o[1], 64'd1);
                found = 1'b1;
            end
        end
        if (!found) chk("t2_timeout", 64'd0, 64'd1);
        wr(32'h4000, 32'h100, 4'hF);
        chk("t2_mtip_clear", mtip_o[1], 64'd0);

        // mtime wraparound with mtimecmp=0
        do_reset();
        wr(32'h4000, 32'h0, 4'hF);
        wr(32'h4004, 32'h0, 4'hF);
        wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        wr(32'hBFFC, 32'hFFFF_FFFF, 4'hF);
        chk("t3_mtip_hi", mtip_o[1], 64'd1);
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            idle();
            chk("t3_mtip", mtip_o[1], 64'd1);
            if (mtime_o[1] == 64'd0) found = 1'b1;
        end
        if (!found) chk("t3_wrap_timeout", 64'd0, 64'd1);

        // msip byte strobes
        wr(32'h0000, 32'hFFFF_FFFF, 4'b0001);
        chk("t4_msip_set", msip_o[1], 64'd1);
        rd(32'h0000);
        chk("t4_msip_rd", rdata_o[1], 64'd1);
        wr(32'h0000, 32'h0, 4'b0001);
        chk("t4_msip_clr", msip_o[0], 64'd0);
        wr(32'h0000, 32'hFFFF_FFFF, 4'b0010);
        chk("t4_msip_strb", msip_o[1], 64'd0);

        // unmapped offsets and back-to-back reads
        rd(32'h1234);
        chk("t5_unmapped_rd", rdata_o[1], 64'd0);
        chk("t5_unmapped_rdy", ready_o[1], 64'd1);
        wr(32'h8000, 32'hDEAD_BEEF, 4'hF);
        for (int k = 0; k < 3; k++) begin
            rd(32'h4004);
            chk("t5_b2b_ready", ready_o[0], 64'd1);
        end
        idle();
        chk("t5_ready_drop", ready_o[0], 64'd0);
        chk("t5_rdata_drop", rdata_o[0], 64'd0);

        // low-then-high read across a carry
        do_reset();
        wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        wr(32'hBFFC, 32'h1, 4'hF);
        rd(32'hBFF8);
        chk("t6_lo", rdata_o[1], 64'hFFFF_FFFF);
        rd(32'hBFFC);
        chk("t6_hi", rdata_o[1], LATCH ? 64'd1 : 64'd2);

        // randomized traffic, occasional reset mid-transaction
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            a = addrs[$urandom_range(0, 6)] | ($urandom & 32'hFFFF_0000);
            rst = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, a,
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64)) : $urandom,
                ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom));
            rst = 1'b0;
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
